// File: rtl/ysyx_22050612_ifu_if.sv
// Instruction-memory port and decode-side instruction handshake of the fetch stage.
// The master modport is the fetch unit; the slave modport is memory plus decode.
interface ysyx_22050612_ifu_if #(
  parameter int XLEN = 64
);
  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_addr;
  logic            imem_resp_valid;
  logic [31:0]     imem_resp_data;
  logic            inst_valid;
  logic            inst_ready;
  logic [31:0]     inst;
  logic [XLEN-1:0] inst_pc;

  modport master (
    output imem_req_valid, imem_addr, inst_valid, inst, inst_pc,
    input  imem_req_ready, imem_resp_valid, imem_resp_data, inst_ready
  );

  modport slave (
    input  imem_req_valid, imem_addr, inst_valid, inst, inst_pc,
    output imem_req_ready, imem_resp_valid, imem_resp_data, inst_ready
  );
endinterface

// File: rtl/ysyx_22050612_ifu.sv
// Instruction fetch: one outstanding fetch at a time, one-entry buffer toward decode,
// redirect from execute and halt from decode.
module ysyx_22050612_ifu #(
  parameter int              XLEN     = 64,
  parameter logic [XLEN-1:0] RESET_PC = 64'h0000_0000_8000_0000
) (
  input  logic                clk,
  input  logic                rst_n,
  ysyx_22050612_ifu_if.master bus,
  input  logic                redirect_valid,
  input  logic [XLEN-1:0]     redirect_pc,
  input  logic                halt,
  output logic                misalign_err,
  output logic                halted
);

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD, S_HALT} state_t;

  state_t          state, state_nxt;
  logic [XLEN-1:0] pc, pc_nxt;
  logic            drop, drop_nxt;
  logic            halt_pend, halt_pend_nxt;
  logic            inst_valid_r, inst_valid_nxt;
  logic [31:0]     inst_r, inst_nxt;
  logic [XLEN-1:0] inst_pc_r, inst_pc_nxt;
  logic            misalign_r, misalign_nxt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= S_REQ;
      pc           <= RESET_PC;
      drop         <= 1'b0;
      halt_pend    <= 1'b0;
      inst_valid_r <= 1'b0;
      inst_r       <= '0;
      inst_pc_r    <= '0;
      misalign_r   <= 1'b0;
    end else begin
      state        <= state_nxt;
      pc           <= pc_nxt;
      drop         <= drop_nxt;
      halt_pend    <= halt_pend_nxt;
      inst_valid_r <= inst_valid_nxt;
      inst_r       <= inst_nxt;
      inst_pc_r    <= inst_pc_nxt;
      misalign_r   <= misalign_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    pc_nxt         = pc;
    drop_nxt       = drop;
    halt_pend_nxt  = halt_pend;
    inst_valid_nxt = inst_valid_r;
    inst_nxt       = inst_r;
    inst_pc_nxt    = inst_pc_r;
    misalign_nxt   = misalign_r;

    if (redirect_valid && state != S_HALT) begin
      // An older branch wins over any ebreak seen after it, so a pending halt is cancelled.
      pc_nxt        = {redirect_pc[XLEN-1:2], 2'b00};
      halt_pend_nxt = 1'b0;
      if (redirect_pc[1:0] != 2'b00) misalign_nxt = 1'b1;
      case (state)
        S_REQ: begin
          if (bus.imem_req_ready) begin
            state_nxt = S_WAIT;
            drop_nxt  = 1'b1;
          end
        end
        S_WAIT: begin
          if (bus.imem_resp_valid) begin
            state_nxt = S_REQ;
            drop_nxt  = 1'b0;
          end else begin
            drop_nxt  = 1'b1;
          end
        end
        S_HOLD: begin
          inst_valid_nxt = 1'b0;
          state_nxt      = S_REQ;
        end
        default: ;
      endcase
    end else begin
      case (state)
        S_REQ: begin
          if (halt)                    state_nxt = S_HALT;
          else if (bus.imem_req_ready) state_nxt = S_WAIT;
        end
        S_WAIT: begin
          if (bus.imem_resp_valid) begin
            if (halt || halt_pend) begin
              state_nxt     = S_HALT;
              halt_pend_nxt = 1'b0;
              drop_nxt      = 1'b0;
            end else if (drop) begin
              state_nxt = S_REQ;
              drop_nxt  = 1'b0;
            end else begin
              inst_nxt       = bus.imem_resp_data;
              inst_pc_nxt    = pc;
              inst_valid_nxt = 1'b1;
              pc_nxt         = pc + XLEN'(4);
              state_nxt      = S_HOLD;
            end
          end else if (halt) begin
            halt_pend_nxt = 1'b1;
          end
        end
        S_HOLD: begin
          if (halt) begin
            inst_valid_nxt = 1'b0;
            state_nxt      = S_HALT;
          end else if (bus.inst_ready) begin
            inst_valid_nxt = 1'b0;
            state_nxt      = S_REQ;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.imem_req_valid = (state == S_REQ);
  assign bus.imem_addr      = pc;
  assign bus.inst_valid     = inst_valid_r;
  assign bus.inst           = inst_r;
  assign bus.inst_pc        = inst_pc_r;
  assign misalign_err       = misalign_r;
  assign halted             = (state == S_HALT);

endmodule

// File: tb/tb_ysyx_22050612_ifu.sv
// Randomised and directed stimulus for the fetch stage; a transaction-level model
// queues expected instructions and a monitor compares them at the decode handshake.
module tb_ysyx_22050612_ifu;
  localparam logic [63:0] RST_PC = 64'h0000_0000_8000_0000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        halt;
  logic        misalign_err;
  logic        halted;

  ysyx_22050612_ifu_if #(.XLEN(64)) bus ();

  ysyx_22050612_ifu #(.XLEN(64), .RESET_PC(RST_PC)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .bus           (bus),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .halt          (halt),
    .misalign_err  (misalign_err),
    .halted        (halted)
  );

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int deliv  = 0;

  // requested inputs for the next clock edge
  logic        d_rst_n = 1'b0, d_ready = 1'b0, d_iready = 1'b0, d_redir = 1'b0, d_halt = 1'b0;
  logic [63:0] d_rpc = '0;
  int          lat_cfg = 0;

  // memory responder
  int          mem_cnt = 0;
  logic [31:0] mem_data = '0;
  logic [31:0] data_q[$];

  // reference model
  typedef struct {
    logic [31:0] d;
    logic [63:0] pc;
    int          cyc;
  } exp_t;
  exp_t        exp_q[$];
  logic [63:0] exp_pc    = RST_PC;
  logic        out_valid = 1'b0;
  logic        out_stale = 1'b0;
  logic        halted_m  = 1'b0;
  logic        mis_m     = 1'b0;
  int          halt_req_cnt = 0;
  logic        prev_hs = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  task automatic apply_inputs();
    rst_n               = d_rst_n;
    bus.imem_req_ready  = d_ready;
    bus.inst_ready      = d_iready;
    redirect_valid      = d_redir;
    redirect_pc         = d_rpc;
    halt                = d_halt;
    bus.imem_resp_valid = 1'b0;
    if (mem_cnt > 0) begin
      mem_cnt--;
      if (mem_cnt == 0) begin
        bus.imem_resp_valid = 1'b1;
        bus.imem_resp_data  = mem_data;
      end
    end
  endtask

  // Model update from the events the coming edge will see.
  task automatic observe();
    cyc++;
    if (!rst_n) begin
      exp_pc = RST_PC; out_valid = 1'b0; out_stale = 1'b0; exp_q.delete();
      halted_m = 1'b0; mis_m = 1'b0; mem_cnt = 0; halt_req_cnt = 0;
      return;
    end
    if (halted_m && bus.imem_req_valid) halt_req_cnt++;
    if (bus.imem_req_valid && bus.imem_req_ready && !halted_m) begin
      chk("fetch_addr", bus.imem_addr, exp_pc);
      chk("one_outstanding", {63'd0, out_valid}, 64'd0);
      out_valid = 1'b1;
      out_stale = redirect_valid;
      mem_data  = (data_q.size() > 0) ? data_q.pop_front() : $urandom;
      mem_cnt   = (lat_cfg > 0) ? lat_cfg : $urandom_range(1, 3);
    end
    if (bus.imem_resp_valid) begin
      if (out_valid && !out_stale && !redirect_valid && !halted_m && !halt) begin
        exp_q.push_back('{d: bus.imem_resp_data, pc: exp_pc, cyc: cyc});
        exp_pc = exp_pc + 64'd4;
      end
      out_valid = 1'b0;
    end
    if (redirect_valid && !halted_m) begin
      exp_pc = {redirect_pc[63:2], 2'b00};
      if (redirect_pc[1:0] != 2'b00) mis_m = 1'b1;
      if (out_valid) out_stale = 1'b1;
      exp_q.delete();
    end else if (halt && !halted_m) begin
      halted_m = 1'b1;
      exp_q.delete();
    end
  endtask

  task automatic tick();
    apply_inputs();
    #1 observe();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Decode-side monitor: compares the buffered instruction with the model queue.
  always begin
    @(negedge clk);
    #3;
    if (rst_n === 1'b1 && !redirect_valid && !halt) begin
      if (prev_hs) chk("valid_one_cycle", {63'd0, bus.inst_valid}, 64'd0);
      prev_hs = 1'b0;
      if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        chk("inst_valid", {63'd0, bus.inst_valid}, 64'd1);
        chk("inst", {32'd0, bus.inst}, {32'd0, exp_q[0].d});
        chk("inst_pc", bus.inst_pc, exp_q[0].pc);
        if (bus.inst_valid && bus.inst_ready) begin
          void'(exp_q.pop_front());
          deliv++;
          prev_hs = 1'b1;
        end
      end else if (bus.inst_valid) begin
        chk("spurious_inst", {63'd0, bus.inst_valid}, 64'd0);
      end
    end else begin
      prev_hs = 1'b0;
    end
  end

  task automatic run_until_deliv(input int n, input int budget, input string nm);
    int start;
    start = deliv;
    for (int i = 0; i < budget; i++) begin
      if (deliv >= start + n) break;
      tick();
    end
    chk(nm, {63'd0, deliv >= start + n}, 64'd1);
  endtask

  task automatic wait_req(input string nm);
    for (int i = 0; i < 40; i++) begin
      if (bus.imem_req_valid) break;
      tick();
    end
    chk(nm, {63'd0, bus.imem_req_valid}, 64'd1);
  endtask

  task automatic wait_cnt(input int k, input string nm);
    for (int i = 0; i < 40; i++) begin
      if (mem_cnt == k) break;
      tick();
    end
    chk(nm, mem_cnt, k);
  endtask

  task automatic pulse_redirect(input logic [63:0] tgt);
    d_redir = 1'b1; d_rpc = tgt;
    tick();
    d_redir = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int start;
    rst_n = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; halt = 1'b0;
    bus.imem_req_ready = 1'b0; bus.imem_resp_valid = 1'b0; bus.imem_resp_data = '0;
    bus.inst_ready = 1'b0;
    @(negedge clk);

    // reset state
    tick(); tick();
    chk("rst_req_valid", {63'd0, bus.imem_req_valid}, 64'd1);
    chk("rst_addr", bus.imem_addr, RST_PC);
    chk("rst_inst_valid", {63'd0, bus.inst_valid}, 64'd0);
    chk("rst_inst", {32'd0, bus.inst}, 64'd0);
    chk("rst_inst_pc", bus.inst_pc, 64'd0);
    chk("rst_misalign", {63'd0, misalign_err}, 64'd0);
    chk("rst_halted", {63'd0, halted}, 64'd0);

    // two back-to-back fetches with 1-cycle memory
    d_rst_n = 1'b1; d_ready = 1'b1; d_iready = 1'b1; lat_cfg = 1;
    data_q.push_back(32'h0000_0513);
    data_q.push_back(32'h0010_0073);
    run_until_deliv(2, 20, "basic_deliveries");

    // decode stalls for 5 cycles
    d_iready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (bus.inst_valid) break;
      tick();
    end
    chk("stall_reach_hold", {63'd0, bus.inst_valid}, 64'd1);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_no_req", {63'd0, bus.imem_req_valid}, 64'd0);
      chk("stall_valid", {63'd0, bus.inst_valid}, 64'd1);
    end
    d_iready = 1'b1;
    run_until_deliv(2, 20, "stall_release");

    // redirect while waiting, response 3 cycles later
    lat_cfg = 4;
    data_q.push_back(32'hDEAD_BEEF);
    wait_cnt(4, "wait_accept_a");
    pulse_redirect(64'h8000_0100);
    wait_req("redir_wait_req");
    chk("redir_wait_addr", bus.imem_addr, 64'h8000_0100);

    // redirect coincident with request acceptance
    lat_cfg = 2; d_ready = 1'b0;
    tick();
    wait_req("redir_acc_req");
    d_ready = 1'b1;
    pulse_redirect(64'h8000_0200);
    wait_req("redir_acc_next");
    chk("redir_acc_addr", bus.imem_addr, 64'h8000_0200);

    // redirect coincident with the response
    wait_cnt(1, "wait_resp_edge");
    pulse_redirect(64'h8000_0300);
    wait_req("redir_resp_next");
    chk("redir_resp_addr", bus.imem_addr, 64'h8000_0300);

    // misaligned redirect target
    d_ready = 1'b0;
    wait_req("mis_req");
    pulse_redirect(64'h8000_0102);
    chk("misalign_set", {63'd0, misalign_err}, 64'd1);
    chk("misalign_addr", bus.imem_addr, 64'h8000_0100);
    d_ready = 1'b1;
    run_until_deliv(1, 20, "misalign_fetch");
    chk("misalign_sticky", {63'd0, misalign_err}, 64'd1);

    // pc wraps past the top of the address space
    d_ready = 1'b0;
    wait_req("wrap_req");
    pulse_redirect(64'hFFFF_FFFF_FFFF_FFFC);
    d_ready = 1'b1;
    run_until_deliv(2, 30, "wrap_deliveries");

    // randomised traffic
    lat_cfg = 0;
    start = deliv;
    for (int i = 0; i < 2000; i++) begin
      d_ready  = ($urandom_range(0, 3) != 0);
      d_iready = ($urandom_range(0, 2) != 0);
      d_redir  = ($urandom_range(0, 19) == 0);
      d_rpc    = {$urandom, $urandom};
      if ($urandom_range(0, 9) != 0) d_rpc[1:0] = 2'b00;
      tick();
    end
    d_redir = 1'b0;
    chk("rand_progress", {63'd0, (deliv - start) > 50}, 64'd1);
    chk("rand_misalign", {63'd0, misalign_err}, {63'd0, mis_m});

    // halt while a fetch is outstanding
    d_ready = 1'b1; d_iready = 1'b1; lat_cfg = 4;
    wait_cnt(4, "halt_accept");
    d_halt = 1'b1;
    tick();
    d_halt = 1'b0;
    for (int i = 0; i < 25; i++) tick();
    chk("halt_halted", {63'd0, halted}, 64'd1);
    chk("halt_no_req", halt_req_cnt, 0);
    chk("halt_inst_valid", {63'd0, bus.inst_valid}, 64'd0);

    // reset restarts fetching
    d_rst_n = 1'b0;
    tick();
    d_rst_n = 1'b1;
    chk("rerst_addr", bus.imem_addr, RST_PC);
    chk("rerst_req_valid", {63'd0, bus.imem_req_valid}, 64'd1);
    chk("rerst_halted", {63'd0, halted}, 64'd0);
    chk("rerst_misalign", {63'd0, misalign_err}, 64'd0);
    lat_cfg = 1;
    run_until_deliv(2, 20, "rerst_resume");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/ysyx_22050612_ifu.md
Name: ysyx_22050612_ifu

Overview:
Instruction fetch stage; sits directly upstream of the decode stage and supplies its 32-bit `inst` input. It holds the PC and issues one fetch at a time over a valid/ready request and valid response instruction-memory port. It buffers one fetched instruction toward decode with a valid/ready handshake. It accepts redirects (branch/jump) from execute and a halt (ebreak) from decode.

Parameters:
- RESET_PC, 64'h0000_0000_8000_0000, PC value loaded on reset.
- XLEN, 64, PC/address width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  synchronous active-low reset.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts request.
- imem_addr  out  XLEN  fetch address (= pc).
- imem_resp_valid  in  1  response valid; exactly one per accepted request, ≥1 cycle after acceptance.
- imem_resp_data  in  32  fetched instruction.
- redirect_valid  in  1  one-cycle redirect pulse from execute.
- redirect_pc  in  XLEN  redirect target.
- halt  in  1  ebreak decoded; stop fetching.
- inst_valid  out  1  instruction buffer valid toward decode.
- inst_ready  in  1  decode consumes instruction.
- inst  out  32  buffered instruction.
- inst_pc  out  XLEN  PC of buffered instruction.
- misalign_err  out  1  sticky: a redirect target had pc[1:0]≠0.
- halted  out  1  fetch stopped.

Behaviour:
- Reset (rst_n=0 at edge): pc=RESET_PC; state=REQ; drop=0; inst_valid=0; inst=0; inst_pc=0; misalign_err=0; halted=0. Memory is reset in the same cycle, so no stale response is outstanding after reset.
- imem_addr=pc always. imem_req_valid=1 only in REQ. Outputs inst/inst_pc/inst_valid are registered.
- States:
  - REQ: on imem_req_ready → WAIT.
  - WAIT: on imem_resp_valid:
    - if drop=1: discard the data, clear drop → REQ.
    - else: inst←data, inst_pc←pc, inst_valid←1, pc←pc+4 → HOLD.
  - HOLD: inst_valid=1. On inst_ready → inst_valid←0 → REQ.
  - HALT: no requests; halted=1; inst_valid=0. Exit only by reset.
- Redirect (redirect_valid=1), priority over normal transitions in that cycle:
  - pc←{redirect_pc[XLEN-1:2],2'b00}. If redirect_pc[1:0]≠0, set misalign_err (sticky until reset).
  - REQ without req_ready: stay REQ; the new pc is used from the next cycle.
  - REQ with req_ready (old address accepted) → WAIT with drop=1.
  - WAIT without resp: drop←1, stay WAIT.
  - WAIT with resp in the same cycle: discard data, drop←0 → REQ.
  - HOLD: inst_valid←0 (instruction squashed even if inst_ready=1 that cycle) → REQ.
- Halt (halt=1, lower priority than redirect, ignored in HALT):
  - From REQ or HOLD → HALT next cycle; the HOLD instruction is dropped.
  - From WAIT: set a pending flag; when the response arrives, discard it → HALT.
- pc+4 wraps modulo 2^XLEN; no error is raised.
- Throughput: at most one instruction per 3 cycles (REQ, WAIT, HOLD); no overlap of fetches.

Test Plan:
- Reset, then imem_req_ready=1, 1-cycle response latency, inst_ready=1, data 32'h00000513/32'h00100073 → inst_pc 0x80000000 then 0x80000004, inst_valid high for exactly one cycle each, correct inst values.
- inst_ready held 0 for 5 cycles in HOLD → inst, inst_pc and inst_valid stable; no new imem_req_valid; on release, next request address is pc+4.
- Redirect to 0x80000100 while in WAIT; response 32'hDEADBEEF arrives 3 cycles later → data discarded, inst_valid stays 0, next request address 0x80000100.
- Redirect in the same cycle as REQ acceptance, and separately in the same cycle as resp_valid → old instruction never reaches decode; next fetch at the redirect target.
- Redirect to 0x80000102 → misalign_err=1 (sticky), fetch address 0x80000100.
- halt asserted in WAIT → pending response dropped, halted=1, imem_req_valid stays 0 for ≥20 cycles; rst_n=0 for one edge → pc=0x80000000, fetching resumes.
